// File: rtl/j1_io_fabric.sv
// j1_io_fabric: I/O interconnect between the J1 core I/O port and up to 16
// peripheral slots.
//
// Each slot occupies one 256-word page starting at BASE_PAGE. The block also
// provides an internal status slot at STATUS_PAGE.
//
// Optional feature macro: J1_IO_FABRIC_TIMEOUT_EN.
//   When defined, the block builds the access timeout counter, the timeout
//   flag and the timeout count register.
//   When undefined, ACCESS waits for the slot's ready indefinitely. Status
//   bit 0 and register 1 then read as zero.
module j1_io_fabric #(
    parameter int          NUM_SLOTS    = 8,
    parameter logic [7:0]  BASE_PAGE    = 8'h67,
    parameter logic [7:0]  STATUS_PAGE  = 8'h7F,
    parameter logic [15:0] DEFAULT_DATA = 16'h0666,
    parameter int          TIMEOUT      = 16
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_i,
    input  logic                      io_rd_i,
    input  logic                      io_wr_i,
    input  logic [15:0]               io_addr_i,
    input  logic [15:0]               io_dout_i,
    output logic [15:0]               io_din_o,
    output logic                      io_stall_o,
    output logic [NUM_SLOTS-1:0]      slot_cs_o,
    output logic                      slot_rd_o,
    output logic                      slot_wr_o,
    output logic [3:0]                slot_addr_o,
    output logic [15:0]               slot_wdata_o,
    input  logic [16*NUM_SLOTS-1:0]   slot_rdata_i,
    input  logic [NUM_SLOTS-1:0]      slot_ready_i,
    output logic                      err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] SLOT_COUNT = 8'(NUM_SLOTS);

    state_t      state_q;
    state_t      state_d;

    logic        req;
    logic [7:0]  page;
    logic [7:0]  page_off;
    logic        is_mapped;
    logic        is_status;
    logic        take_req;
    logic        status_wr;

    logic [3:0]  idx_q;
    logic        wr_q;

    logic        sel_ready;
    logic [15:0] sel_rdata;
    logic        abort;
    logic        timeout_hit;

    logic        um_flag_q;
    logic [7:0]  last_page_q;
    logic        to_flag_rd;
    logic [15:0] to_count_rd;
    logic [15:0] status_rdata;

    logic        unused_ok;

    // Request decode.
    // The subtraction wraps for pages below BASE_PAGE, so a single unsigned
    // compare covers both ends of the slot window.
    assign req       = io_rd_i | io_wr_i;
    assign page      = io_addr_i[15:8];
    assign page_off  = page - BASE_PAGE;
    assign is_mapped = (page_off < SLOT_COUNT);
    assign is_status = (page == STATUS_PAGE);
    assign take_req  = (state_q == IDLE) && req;
    assign status_wr = take_req && io_wr_i && is_status;
    assign unused_ok = ^io_addr_i[7:4];

    // Pick the ready and read data of the latched slot; other slots are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 16'h0000;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == 4'(i)) begin
                sel_ready = slot_ready_i[i];
                sel_rdata = slot_rdata_i[16*i +: 16];
            end
        end
    end

`ifdef J1_IO_FABRIC_TIMEOUT_EN
    logic [7:0]  tcnt_q;
    logic        to_flag_q;
    logic [15:0] to_count_q;

    // tcnt_q holds the number of ACCESS cycles already spent, so it equals
    // TIMEOUT-1 during the last allowed cycle.
    assign timeout_hit = (state_q == ACCESS) && (tcnt_q == 8'(TIMEOUT - 1));

    // An abort only happens when ready is absent; ready in the final cycle wins.
    assign abort       = timeout_hit && !sel_ready;
    assign to_flag_rd  = to_flag_q;
    assign to_count_rd = to_count_q;

    // Count ACCESS cycles; restart at zero for every transaction.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            tcnt_q <= 8'd0;
        end else if (state_q == ACCESS) begin
            tcnt_q <= tcnt_q + 8'd1;
        end else begin
            tcnt_q <= 8'd0;
        end
    end

    // Sticky timeout flag and saturating abort counter, cleared from the status slot.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            to_flag_q  <= 1'b0;
            to_count_q <= 16'h0000;
        end else if (abort) begin
            to_flag_q <= 1'b1;
            if (to_count_q != 16'hFFFF) begin
                to_count_q <= to_count_q + 16'd1;
            end
        end else if (status_wr) begin
            if (io_addr_i[3:0] == 4'd0 && io_dout_i[0]) begin
                to_flag_q <= 1'b0;
            end
            if (io_addr_i[3:0] == 4'd1) begin
                to_count_q <= 16'h0000;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
    assign to_flag_rd  = 1'b0;
    assign to_count_rd = 16'h0000;
`endif

    // Status slot read view.
    always_comb begin
        status_rdata = 16'h0000;
        case (io_addr_i[3:0])
            4'd0:    status_rdata = {last_page_q, 6'b000000, um_flag_q, to_flag_rd};
            4'd1:    status_rdata = to_count_rd;
            default: status_rdata = 16'h0000;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs.
    // Strobes and stall are decoded from the state register, so an
    // asynchronous reset drops them at once.
    always_comb begin
        state_d    = state_q;
        slot_cs_o  = '0;
        slot_rd_o  = 1'b0;
        slot_wr_o  = 1'b0;
        io_stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                io_stall_o = sys_rst_i & req;
                if (req) begin
                    state_d = is_mapped ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                io_stall_o = sys_rst_i;
                slot_rd_o  = !wr_q;
                slot_wr_o  = wr_q;
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    slot_cs_o[i] = (idx_q == 4'(i));
                end
                if (sel_ready || timeout_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the transaction when it is accepted in IDLE.
    // The write strobe wins over the read strobe.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            slot_addr_o  <= 4'd0;
            slot_wdata_o <= 16'h0000;
            idx_q        <= 4'd0;
            wr_q         <= 1'b0;
        end else if (take_req) begin
            slot_addr_o  <= io_addr_i[3:0];
            slot_wdata_o <= io_dout_i;
            idx_q        <= page_off[3:0];
            wr_q         <= io_wr_i;
        end
    end

    // Registered read data.
    // Status and unmapped reads complete on acceptance. Slot reads complete
    // on ready, or on abort. Writes never touch the register.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            io_din_o <= 16'h0000;
        end else if (take_req && !io_wr_i && !is_mapped) begin
            io_din_o <= is_status ? status_rdata : DEFAULT_DATA;
        end else if (state_q == ACCESS && !wr_q) begin
            if (sel_ready) begin
                io_din_o <= sel_rdata;
            end else if (abort) begin
                io_din_o <= DEFAULT_DATA;
            end
        end
    end

    // Sticky unmapped flag and the page of the most recent error.
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            um_flag_q   <= 1'b0;
            last_page_q <= 8'h00;
        end else if (take_req && !is_mapped && !is_status) begin
            um_flag_q   <= 1'b1;
            last_page_q <= page;
        end else if (abort) begin
            last_page_q <= BASE_PAGE + {4'b0000, idx_q};
        end else if (status_wr && io_addr_i[3:0] == 4'd0 && io_dout_i[1]) begin
            um_flag_q <= 1'b0;
        end
    end

    assign err_o = to_flag_rd | um_flag_q;

endmodule

// File: tb/tb_j1_io_fabric.sv
// Scoreboard bench for j1_io_fabric.
// The driver predicts each transaction's outcome from a transaction-level
// model and queues it. The monitor checks strobes while stalled, and checks
// latency, read data and err_o when the stall falls.
`timescale 1ns/1ps
module tb_j1_io_fabric;

    localparam int          NUM  = 8;
    localparam logic [7:0]  BASE = 8'h67;
    localparam logic [7:0]  STAT = 8'h7F;
    localparam logic [15:0] DEF  = 16'h0666;
    localparam int          TOUT = 16;
`ifdef J1_IO_FABRIC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 io_rd, io_wr;
    logic [15:0]          io_addr, io_dout, io_din;
    logic                 io_stall;
    logic [NUM-1:0]       slot_cs;
    logic                 slot_rd, slot_wr;
    logic [3:0]           slot_addr;
    logic [15:0]          slot_wdata;
    logic [16*NUM-1:0]    slot_rdata;
    logic [NUM-1:0]       slot_ready;
    logic                 err;

    always #5 clk = ~clk;

    j1_io_fabric #(
        .NUM_SLOTS(NUM), .BASE_PAGE(BASE), .STATUS_PAGE(STAT),
        .DEFAULT_DATA(DEF), .TIMEOUT(TOUT)
    ) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n),
        .io_rd_i(io_rd), .io_wr_i(io_wr), .io_addr_i(io_addr), .io_dout_i(io_dout),
        .io_din_o(io_din), .io_stall_o(io_stall),
        .slot_cs_o(slot_cs), .slot_rd_o(slot_rd), .slot_wr_o(slot_wr),
        .slot_addr_o(slot_addr), .slot_wdata_o(slot_wdata),
        .slot_rdata_i(slot_rdata), .slot_ready_i(slot_ready), .err_o(err)
    );

    typedef struct {
        logic [15:0]    din;
        logic           err;
        int             lat;
        bit             mapped;
        logic [NUM-1:0] cs;
        bit             wr;
        logic [3:0]     a;
        logic [15:0]    wd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b1;
    int   hi_cnt = 0;

    // Reference model state
    logic [15:0] m_din  = 16'h0000;
    bit          m_to   = 1'b0;
    bit          m_um   = 1'b0;
    logic [7:0]  m_last = 8'h00;
    int          m_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction-level prediction; d = ready delay after the first slot cycle, -1 = never.
    task automatic predict(input bit wr, input logic [15:0] addr, input logic [15:0] wdata, input int d);
        exp_t       e;
        int         off;
        logic [7:0] page;
        page     = addr[15:8];
        off      = int'(page) - int'(BASE);
        e.mapped = (off >= 0 && off < NUM);
        e.cs     = '0;
        e.wr     = wr;
        e.a      = addr[3:0];
        e.wd     = wdata;
        if (e.mapped) begin
            e.cs[off] = 1'b1;
            if (TO_EN && (d < 0 || d >= TOUT)) begin
                if (!wr) m_din = DEF;
                m_to = 1'b1;
                if (m_cnt < 65535) m_cnt++;
                m_last = page;
                e.lat  = TOUT + 1;
            end else begin
                if (!wr) m_din = slot_rdata[off*16 +: 16];
                e.lat = d + 2;
            end
        end else if (page == STAT) begin
            e.lat = 1;
            if (wr) begin
                if (addr[3:0] == 4'd0) begin
                    if (wdata[0]) m_to = 1'b0;
                    if (wdata[1]) m_um = 1'b0;
                end else if (addr[3:0] == 4'd1) begin
                    m_cnt = 0;
                end
            end else begin
                case (addr[3:0])
                    4'd0:    m_din = {m_last, 6'b000000, m_um, m_to};
                    4'd1:    m_din = 16'(m_cnt);
                    default: m_din = 16'h0000;
                endcase
            end
        end else begin
            m_um   = 1'b1;
            m_last = page;
            if (!wr) m_din = DEF;
            e.lat  = 1;
        end
        e.din = m_din;
        e.err = m_to | m_um;
        exp_q.push_back(e);
    endtask

    // Drive one transaction and hold it until the stall falls, then return to IDLE.
    task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input int d);
        int       c;
        bit       done;
        int       off;
        logic [NUM-1:0] rdy;
        predict(wr, addr, wdata, d);
        off = int'(addr[15:8]) - int'(BASE);
        @(posedge clk); #1;
        io_rd = rd; io_wr = wr; io_addr = addr; io_dout = wdata;
        c = 0;
        done = 1'b0;
        while (!done && c < 300) begin
            @(posedge clk); #1;
            c++;
            if (!io_stall) begin
                done = 1'b1;
            end else begin
                rdy = NUM'($urandom);
                if (off >= 0 && off < NUM) rdy[off] = (d >= 0 && c >= d + 1);
                slot_ready = rdy;
            end
        end
        io_rd = 1'b0; io_wr = 1'b0; slot_ready = '0;
        if (!done) begin
            errors++;
            $display("FAIL txn_wait: stall still %b after %0d cycles, required 0", io_stall, c);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "transaction hung");
        end
        @(posedge clk); #1;
    endtask

    // Monitor: strobe checks while stalled, completion checks when the stall drops.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (io_stall) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_stall", 32'(io_stall), 32'd0);
                    end else begin
                        e = exp_q[0];
                        if (hi_cnt >= 1 && e.mapped) begin
                            chk("slot_cs", 32'(slot_cs), 32'(e.cs));
                            chk("slot_rd", 32'(slot_rd), 32'(!e.wr));
                            chk("slot_wr", 32'(slot_wr), 32'(e.wr));
                            chk("slot_addr", 32'(slot_addr), 32'(e.a));
                            if (e.wr) chk("slot_wdata", 32'(slot_wdata), 32'(e.wd));
                        end else begin
                            chk("strobes_quiet", {slot_cs, slot_rd, slot_wr}, '0);
                        end
                    end
                    hi_cnt++;
                end else if (hi_cnt > 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(hi_cnt), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("latency", 32'(hi_cnt), 32'(e.lat));
                        chk("io_din", 32'(io_din), 32'(e.din));
                        chk("err_o", 32'(err), 32'(e.err));
                        chk("done_strobes", {slot_cs, slot_rd, slot_wr}, '0);
                    end
                    hi_cnt = 0;
                end
            end
        end
    end

    task automatic run_random(input int n_txn);
        logic [7:0]  um_pages [6];
        int          kind;
        int          d;
        logic [15:0] a;
        logic [15:0] w;
        bit          rd;
        bit          wr;
        um_pages = '{8'h00, 8'h40, 8'h66, 8'h6F, 8'h80, 8'hFF};
        for (int n = 0; n < n_txn; n++) begin
            slot_rdata = {$urandom, $urandom, $urandom, $urandom};
            kind = $urandom_range(0, 9);
            w    = 16'($urandom);
            d    = $urandom_range(0, 4);
            if (TO_EN && $urandom_range(0, 7) == 0) d = $urandom_range(TOUT - 1, TOUT);
            a    = {BASE + 8'($urandom_range(0, NUM - 1)), 8'($urandom)};
            rd   = 1'b1;
            wr   = 1'b0;
            case (kind)
                0, 1, 2, 3, 4: begin
                    wr = 1'($urandom);
                    rd = !wr;
                end
                5: wr = 1'b1;
                6: a = {um_pages[$urandom_range(0, 5)], 8'($urandom)};
                7, 8: a = {STAT, 6'd0, 2'($urandom)};
                default: begin
                    a  = {STAT, 6'd0, 2'($urandom_range(0, 2))};
                    w  = {14'd0, 2'($urandom)};
                    rd = 1'b0;
                    wr = 1'b1;
                end
            endcase
            run_txn(rd, wr, a, w, d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "global timeout");
    end

    initial begin
        rst_n = 1'b0;
        io_rd = 1'b0; io_wr = 1'b0; io_addr = '0; io_dout = '0;
        slot_rdata = '0; slot_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_din", 32'(io_din), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", {slot_cs, slot_rd, slot_wr, io_stall}, '0);
        chk("rst_latched", {slot_addr, slot_wdata}, '0);

        // Slot 1 read, ready on the first slot cycle
        slot_rdata[31:16] = 16'hBEEF;
        run_txn(1'b1, 1'b0, 16'h6800, 16'h0000, 0);
        // Slot 0 write with ready three cycles late
        run_txn(1'b0, 1'b1, 16'h6705, 16'h1234, 3);
`ifdef J1_IO_FABRIC_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 16'h6C00, 16'h0000, -1);
        run_txn(1'b1, 1'b0, 16'h7F00, 16'h0000, 0);
        run_txn(1'b1, 1'b0, 16'h7F01, 16'h0000, 0);
`endif
        // Unmapped read, then clear both flags from the status slot
        run_txn(1'b1, 1'b0, 16'h4000, 16'h0000, 0);
        run_txn(1'b1, 1'b0, 16'h7F00, 16'h0000, 0);
        run_txn(1'b0, 1'b1, 16'h7F00, 16'h0003, 0);
        run_txn(1'b1, 1'b0, 16'h7F00, 16'h0000, 0);
        // Both strobes: the write wins
        run_txn(1'b1, 1'b1, 16'h6900, 16'hA5A5, 1);

        run_random(80);

        // Reset during ACCESS
        run_txn(1'b1, 1'b0, 16'h4000, 16'h0000, 0);
        mon_en = 1'b0;
        @(posedge clk); #1;
        io_rd = 1'b1; io_addr = 16'h6A07; io_dout = 16'hC3C3; slot_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_cs", 32'(slot_cs), 32'h0000_0008);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobes", {slot_cs, slot_rd, slot_wr, io_stall}, '0);
        chk("mid_rst_din", 32'(io_din), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        io_rd = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_latched", {slot_addr, slot_wdata}, '0);
        chk("post_rst_idle", {slot_cs, slot_rd, slot_wr, io_stall}, '0);
        exp_q.delete();
        hi_cnt = 0;
        m_din = 16'h0000; m_to = 1'b0; m_um = 1'b0; m_last = 8'h00; m_cnt = 0;
        mon_en = 1'b1;
        run_txn(1'b1, 1'b0, 16'h7F00, 16'h0000, 0);
        run_txn(1'b1, 1'b0, 16'h7F01, 16'h0000, 0);

        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/j1_io_fabric.md
# j1_io_fabric

Parametrised I/O interconnect between the J1 core's I/O port and up to 16 peripheral slots. It replaces the fixed chip-select decoder and read mux with a page decoder that computes the slot number, a transaction state machine with a ready/stall handshake, registered read data and an access timeout. Error reporting is an internal status slot. The block sits between `j1` and the peripheral instances in the SoC top.

## Interface
- `NUM_SLOTS`, 8: number of peripheral slots, 1..16.
- `BASE_PAGE`, 8'h67: `io_addr_i[15:8]` value of slot 0. Slot i is at page `BASE_PAGE+i`, binary contiguous.
- `STATUS_PAGE`, 8'h7F: page of the internal status slot. It must lie outside the slot range.
- `DEFAULT_DATA`, 16'h0666: read value for unmapped or aborted accesses.
- `TIMEOUT`, 16: maximum ACCESS cycles to wait for `slot_ready_i`, 2..255.

Ports:
- `sys_clk_i` in 1: the single clock; all logic is on the rising edge.
- `sys_rst_i` in 1: reset, asynchronous, active-low.
- `io_rd_i` in 1: CPU read strobe.
- `io_wr_i` in 1: CPU write strobe.
- `io_addr_i` in 16: CPU address.
- `io_dout_i` in 16: CPU write data.
- `io_din_o` out 16: registered read data to the CPU.
- `io_stall_o` out 1: CPU must hold its strobe, address and data while this is high.
- `slot_cs_o` out NUM_SLOTS: one-hot slot select.
- `slot_rd_o` out 1: slot read strobe.
- `slot_wr_o` out 1: slot write strobe.
- `slot_addr_o` out 4: latched `io_addr_i[3:0]`.
- `slot_wdata_o` out 16: latched write data.
- `slot_rdata_i` in 16*NUM_SLOTS: slot i read data at bits [16i+15:16i].
- `slot_ready_i` in NUM_SLOTS: slot i completes the access.
- `err_o` out 1: OR of the sticky error flags.

## Operation
- The FSM has three states: IDLE, ACCESS, DONE.
- **IDLE:**
  - On `io_rd_i|io_wr_i` the block latches the address, write data, slot index (page−BASE_PAGE) and direction.
  - If both strobes are high, the write wins and the read is ignored.
  - A mapped slot goes to ACCESS.
  - An unmapped page or STATUS_PAGE goes to DONE.
- **ACCESS:**
  - `slot_cs_o[idx]` is high, together with `slot_rd_o` or `slot_wr_o`.
  - The block samples `slot_ready_i[idx]` every cycle.
  - On ready, a read captures `slot_rdata_i[idx]` into `io_din_o`. Next state is DONE.
  - On timeout, `io_din_o` is set to DEFAULT_DATA (for a read), the timeout flag is set and the timeout count increments. Next state is DONE.
- **DONE:** all slot strobes are low and `io_stall_o` is low. Next state is IDLE; any request present in DONE is ignored.
- **Unmapped page:**
  - The unmapped flag is set.
  - A read returns DEFAULT_DATA.
  - A write is dropped.
- **Status slot** (`io_addr_i[3:0]`):
  - Register 0 read: `{11'b0, last_err_slot[3:0], ...}` is replaced by the exact layout `[15:8]` last erroring page, `[1]` unmapped flag, `[0]` timeout flag.
  - Register 0 write: writing 1 to bit 0 or bit 1 clears the corresponding flag.
  - Register 1 read: timeout count, 16 bit, saturates at 16'hFFFF. Any write to register 1 clears it.
  - Other registers read 16'h0000; writes to them are ignored.
- `io_din_o` holds its value until the next read completes; writes leave it unchanged.
- `err_o` = timeout flag | unmapped flag.

## Timing
- **Reset values:**
  - State: IDLE.
  - `io_din_o`, `slot_addr_o`, `slot_wdata_o`: 0.
  - `slot_cs_o`, `slot_rd_o`, `slot_wr_o`: 0.
  - Flags, count and last erroring page: 0.
  - `err_o`: 0.
- **Reset mid-operation:** strobes drop immediately (asynchronous) and the transaction is discarded.
- `io_stall_o` is combinational: (IDLE & (rd|wr)) | ACCESS.
- **Cycle timing:**
  - Request seen at cycle 0.
  - Slot strobes are high from cycle 1.
  - If ready arrives at cycle k≥1, DONE is at cycle k+1 and `io_din_o` is valid from cycle k+1.
  - Minimum slot-access latency is 2 cycles.
  - Unmapped and status accesses reach DONE at cycle 1.
- **Timeout:** if ready is still low after TIMEOUT ACCESS cycles, the abort is taken at the end of ACCESS cycle TIMEOUT.
- Ready and timeout on the same cycle: ready wins, and no flag is set.
- Ready from a non-selected slot is ignored.

## Configuration
- `J1_IO_FABRIC_TIMEOUT_EN` defined:
  - The timeout counter, timeout flag and count register are built.
- Undefined:
  - ACCESS waits indefinitely for ready.
  - Status bit 0 and register 1 read 0.
  - Writes to them have no effect.

## Test plan
- Read page 8'h68 (slot 1), slot 1 ready on the first ACCESS cycle with rdata 16'hBEEF -> `slot_cs_o`=8'b0000_0010 at cycle 1; `io_din_o`=16'hBEEF at cycle 2; stall high cycles 0–1.
- Write 16'h1234 to 16'h6705 with ready delayed 3 cycles -> `slot_wdata_o`=16'h1234, `slot_addr_o`=5; `slot_wr_o` high cycles 1–4; `io_din_o` unchanged.
- Read page 8'h6C with ready never asserted and TIMEOUT=16 -> DONE at cycle 17; `io_din_o`=16'h0666; `err_o`=1; status reg 0 reads 16'h6C01; reg 1 reads 1.
- Read page 8'h40 -> no slot strobe; `io_din_o`=16'h0666; unmapped flag set. Writing 16'h0003 to 16'h7F00 clears the flags and `err_o`=0.
- Assert `sys_rst_i`=0 during ACCESS -> all strobes and stall drop within the same cycle; after release the block is in IDLE with all registers 0.
- Assert rd and wr together on 16'h6900 -> only `slot_wr_o` pulses.
